// File: rtl/sub_arb_ctrl.sv
// Round-robin owner arbiter for the shared sub_b: grant, hold until done, one dead cycle.
// Optional forced release after MAX_HOLD owned cycles: define SUB_ARB_CTRL_TIMEOUT_EN.
module sub_arb_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] sub_a__arb__req,
    input  logic [NUM_REQ-1:0] sub_a__arb__done,
    output logic [NUM_REQ-1:0] arb__sub_a__gnt,
    output logic [SEL_W-1:0]   arb__sub_b__sel,
    output logic               arb__sub_b__vld,
    output logic               arb__top__busy,
    output logic               arb__top__timeout
);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   win;
    logic               any_req;
    logic               owner_rel;
    logic               hold_exp;

    assign any_req   = |sub_a__arb__req;
    assign owner_rel = sub_a__arb__done[sel_q] | ~sub_a__arb__req[sel_q];

    // First requester strictly after the last winner, wrapping.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && sub_a__arb__req[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

`ifdef SUB_ARB_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q;

    assign hold_exp = (cnt_q == CNT_W'(MAX_HOLD - 1));

    // Counter is held at zero outside OWN, so it is clear on the first owned cycle.
    always_comb begin
        cnt_d = '0;
        if (state_q == OWN) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= (state_q == OWN) && !owner_rel && hold_exp;
        end
    end

    assign arb__top__timeout = tmo_q;
`else
    assign hold_exp          = 1'b0;
    assign arb__top__timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = NUM_REQ'(1) << win;
                    sel_d   = win;
                    ptr_d   = win;
                    state_d = OWN;
                end
            end
            OWN: begin
                // A natural release wins over an expiring hold.
                if (owner_rel || hold_exp) begin
                    gnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign arb__sub_a__gnt = gnt_q;
    assign arb__sub_b__sel = sel_q;
    assign arb__sub_b__vld = |gnt_q;
    assign arb__top__busy  = (state_q != IDLE);
endmodule

// File: tb/tb_sub_arb_ctrl.sv
// Directed bench for sub_arb_ctrl; expected grant owners queued at stimulus time.
module tb_sub_arb_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld, busy, tmo;

    int passed = 0;
    int total  = 0;
    int exp_q[$];

    sub_arb_ctrl #(.NUM_REQ(4), .SEL_W(2), .MAX_HOLD(16), .CNT_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .sub_a__arb__req   (req),
        .sub_a__arb__done  (done),
        .arb__sub_a__gnt   (gnt),
        .arb__sub_b__sel   (sel),
        .arb__sub_b__vld   (vld),
        .arb__top__busy    (busy),
        .arb__top__timeout (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    // Wait (bounded) for a grant, pop the expected owner and compare; returns idle cycles seen.
    task automatic expect_grant(input string tag, output int zeros);
        int e;
        zeros = 0;
        while (gnt == 4'b0 && zeros < 12) begin
            zeros++;
            tick();
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << e));
            chk({tag, "_sel"}, 32'(sel), 32'(e));
            chk({tag, "_vld"}, 32'(vld), 32'd1);
        end
    endtask

    initial begin
        int z;
        bit saw_tmo;

        // Reset state
        rst = 1'b1; req = '0; done = '0;
        #13;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        #4 rst = 1'b0;
        tick();

        // Single requester: 1-cycle latency, release on done, GAP then IDLE
        req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'(sel), 32'd0);
        chk("t1_vld", 32'(vld), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        tick(); tick(); tick();
        done = 4'b0001; req = 4'b0000;
        tick();
        done = '0;
        chk("t1_rel_gnt", 32'(gnt), 32'd0);
        chk("t1_rel_vld", 32'(vld), 32'd0);
        chk("t1_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // All requesting: round-robin order 0,1,2,3,0 with a 2-cycle hole between owners
        do_reset();
        req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        tick();
        expect_grant("rr0", z);
        chk("rr0_latency", 32'(z), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick(); tick();
            done = gnt;
            tick();
            done = '0;
            expect_grant($sformatf("rr%0d", k), z);
            chk($sformatf("rr%0d_hole", k), 32'(z), 32'd2);
        end
        req = '0;
        tick(); tick(); tick();
        chk("rr_idle", 32'(busy), 32'd0);

        // Owner 2 drops req without done; 3 must be next
        req = 4'b1100;
        exp_q.push_back(2);
        tick();
        expect_grant("drop_a", z);
        tick();
        req = 4'b1000;
        exp_q.push_back(3);
        tick();
        chk("drop_rel", 32'(gnt), 32'd0);
        expect_grant("drop_b", z);
        chk("drop_hole", 32'(z), 32'd2);
        req = '0;
        tick(); tick(); tick();

        // Done pulses from non-owners are ignored
        req = 4'b0010;
        exp_q.push_back(1);
        tick();
        expect_grant("nonown", z);
        done = 4'b1001;
        tick();
        done = '0;
        chk("nonown_hold1", 32'(gnt), 32'h2);
        tick();
        chk("nonown_hold2", 32'(gnt), 32'h2);
        chk("nonown_busy", 32'(busy), 32'd1);
        req = '0;
        tick(); tick(); tick();

        // Owner 0 never finishes
        do_reset();
        req = 4'b0011;
        exp_q.push_back(0);
        tick();
        expect_grant("hold", z);
        saw_tmo = 1'b0;
`ifdef SUB_ARB_CTRL_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            if (tmo) saw_tmo = 1'b1;
        end
        chk("to_held16", 32'(gnt), 32'h1);
        chk("to_early", 32'(saw_tmo), 32'd0);
        tick();
        chk("to_rel_gnt", 32'(gnt), 32'd0);
        chk("to_pulse", 32'(tmo), 32'd1);
        tick();
        chk("to_pulse_end", 32'(tmo), 32'd0);
        exp_q.push_back(1);
        expect_grant("to_next", z);
        chk("to_hole", 32'(z), 32'd1);
`else
        for (int i = 0; i < 24; i++) begin
            tick();
            if (tmo) saw_tmo = 1'b1;
        end
        chk("nto_held", 32'(gnt), 32'h1);
        chk("nto_tmo", 32'(saw_tmo), 32'd0);
`endif
        req = '0;
        tick(); tick(); tick();

        // Asynchronous reset mid-ownership, then fresh arbitration from pointer 3
        req = 4'b0100;
        tick();
        chk("ar_own", 32'(gnt), 32'h4);
        #3 rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'd0);
        chk("ar_vld", 32'(vld), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        req = 4'b1000;
        exp_q.push_back(3);
        tick();
        expect_grant("ar_next", z);
        chk("ar_latency", 32'(z), 32'd0);
        chk("ar_busy2", 32'(busy), 32'd1);

        req = '0;
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
